// File: rtl/imem_arbiter.sv
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares one combinational instruction-ROM read port between IF
//            and LS requesters; one-cycle registered response, address
//            range/alignment error flag, saturating IF stall counter.
//            Define ARB_RR_EN for round-robin contention, else LS wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arbiter #(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = 32'hBFC00000,
  parameter int unsigned                MEM_BYTES     = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]  if_req_addr,
  output logic                      if_req_ready,
  output logic                      if_rsp_valid,
  output logic [ADDRESS_WIDTH-1:0]  if_rsp_data,
  output logic                      if_rsp_err,
  input  logic                      ls_req_valid,
  input  logic [ADDRESS_WIDTH-1:0]  ls_req_addr,
  output logic                      ls_req_ready,
  output logic                      ls_rsp_valid,
  output logic [ADDRESS_WIDTH-1:0]  ls_rsp_data,
  output logic                      ls_rsp_err,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  input  logic [ADDRESS_WIDTH-1:0]  mem_dout,
  output logic [15:0]               if_stall_cnt
);

  // Offset of the last legal word; comparing offsets avoids BASE+SIZE overflow.
  localparam logic [ADDRESS_WIDTH-1:0] c_last_offset = ADDRESS_WIDTH'(MEM_BYTES - 4);

  logic                     r_last_grant;
  logic                     w_ls_wins;
  logic                     w_grant_if;
  logic                     w_grant_ls;
  logic [ADDRESS_WIDTH-1:0] w_gnt_addr;
  logic [ADDRESS_WIDTH-1:0] w_offset;
  logic                     w_err;

`ifdef ARB_RR_EN
  assign w_ls_wins = ~r_last_grant;
`else
  // Fixed priority: LS always wins; last_grant is tracked but does not steer.
  assign w_ls_wins = r_last_grant | 1'b1;
`endif

  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ls = 1'b0;
    if (!rst) begin
      w_grant_ls = ls_req_valid & (~if_req_valid | w_ls_wins);
      w_grant_if = if_req_valid & ~(ls_req_valid & w_ls_wins);
    end
  end

  assign if_req_ready = w_grant_if;
  assign ls_req_ready = w_grant_ls;

  always_comb begin
    w_gnt_addr = w_grant_ls ? ls_req_addr : if_req_addr;
    w_offset   = w_gnt_addr - BASE_ADDR;
    w_err      = (w_gnt_addr[1:0] != 2'b00) || (w_gnt_addr < BASE_ADDR) ||
                 (w_offset > c_last_offset);
    mem_addr   = BASE_ADDR;
    if ((w_grant_if || w_grant_ls) && !w_err) begin
      mem_addr = w_gnt_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_err   <= 1'b0;
      ls_rsp_valid <= 1'b0;
      ls_rsp_data  <= '0;
      ls_rsp_err   <= 1'b0;
      if_stall_cnt <= 16'd0;
    end else begin
      if_rsp_valid <= w_grant_if;
      ls_rsp_valid <= w_grant_ls;
      if (w_grant_if) begin
        if_rsp_data <= w_err ? '0 : mem_dout;
        if_rsp_err  <= w_err;
      end
      if (w_grant_ls) begin
        ls_rsp_data <= w_err ? '0 : mem_dout;
        ls_rsp_err  <= w_err;
      end
      if (w_grant_if || w_grant_ls) begin
        r_last_grant <= w_grant_ls;
      end
      if (if_req_valid && !w_grant_if && (if_stall_cnt != 16'hFFFF)) begin
        if_stall_cnt <= if_stall_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire
